bus_arbiter: RTL and testbench

Two-master, one-slave arbiter sharing the single memory bus between the instruction-fetch stage and the Memory stage. Forwards the granted requester's address, request and write data to the memory port and returns per-master `rw_wait`. Data (Memory stage) normally wins; a starvation counter guarantees fetch progress, and a lock input keeps LDM/STM bursts uninterrupted. Zero-cycle arbitration overhead: a transaction the memory accepts immediately completes in the cycle it is requested.

---
 rtl/bus_arbiter_if.sv | 45 ++++
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared memory bus between fetch, Memory stage and memory.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface bus_arbiter_if;
    logic        ic_rd_req;
    logic [31:0] ic_busaddr;
    logic        ic_rw_wait;
    logic [31:0] ic_rd_data;

    logic        dc_rd_req;
    logic        dc_wr_req;
    logic [31:0] dc_busaddr;
    logic [31:0] dc_wr_data;
    logic        dc_lock;
    logic        dc_rw_wait;
    logic [31:0] dc_rd_data;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic        mem_ready;
    logic [31:0] mem_rd_data;

    logic        grant_d;

    modport slave (
        input  ic_rd_req, ic_busaddr,
        output ic_rw_wait, ic_rd_data,
        input  dc_rd_req, dc_wr_req, dc_busaddr, dc_wr_data, dc_lock,
        output dc_rw_wait, dc_rd_data,
        output mem_addr, mem_rd, mem_wr, mem_wr_data,
        input  mem_ready, mem_rd_data,
        output grant_d
    );

    modport master (
        output ic_rd_req, ic_busaddr,
        input  ic_rw_wait, ic_rd_data,
        output dc_rd_req, dc_wr_req, dc_busaddr, dc_wr_data, dc_lock,
        input  dc_rw_wait, dc_rd_data,
        input  mem_addr, mem_rd, mem_wr, mem_wr_data,
        output mem_ready, mem_rd_data,
        input  grant_d
    );
endinterface

// File: rtl/bus_arbiter.sv
// Fetch / Memory-stage arbiter for the single memory port: data-first priority,
// starvation escape for fetch, burst lock, zero-cycle arbitration.
//
// owner    | meaning
// ---------+------------------------------------------------------------
// OWN_NONE | no transaction in flight; next request is arbitrated fresh
// OWN_I    | fetch read accepted but not yet completed by memory
// OWN_D    | data access in flight, or locked burst between beats
module bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           Nrst,
    bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_t     owner_q, owner_d;
    owner_t     sel;
    logic [3:0] starve_q, starve_d;
    logic       grant_d_q, grant_d_d;

    logic ic_req;
    logic dc_req;
    logic fetch_forced;
    logic complete;

    assign ic_req       = bus.ic_rd_req;
    assign dc_req       = bus.dc_rd_req | bus.dc_wr_req;
    assign fetch_forced = (starve_q == STARVE_LIM) && !bus.dc_lock;

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            owner_q   <= OWN_NONE;
            starve_q  <= '0;
            grant_d_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            grant_d_q <= grant_d_d;
        end
    end

    // An owner that withdraws its request falls through to fresh arbitration in the same cycle.
    always_comb begin
        sel = OWN_NONE;
        if (!Nrst) begin
            sel = OWN_NONE;
        end else if (owner_q == OWN_I && ic_req) begin
            sel = OWN_I;
        end else if (owner_q == OWN_D && dc_req) begin
            sel = OWN_D;
        end else if (ic_req && dc_req) begin
            sel = fetch_forced ? OWN_I : OWN_D;
        end else if (ic_req) begin
            sel = OWN_I;
        end else if (dc_req) begin
            sel = OWN_D;
        end
    end

    assign complete = (sel != OWN_NONE) && bus.mem_ready;

    always_comb begin
        owner_d   = owner_q;
        starve_d  = starve_q;
        grant_d_d = grant_d_q;

        if (sel == OWN_NONE) begin
            owner_d = OWN_NONE;
        end else if (!bus.mem_ready) begin
            owner_d = sel;
        end else if (sel == OWN_D && bus.dc_lock) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end

        if (complete) begin
            grant_d_d = (sel == OWN_D);
        end

        if (!ic_req) begin
            starve_d = '0;
        end else if (complete && sel == OWN_I) begin
            starve_d = '0;
        end else if (complete && sel == OWN_D && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        bus.mem_addr    = 'x;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_wr_data = 'x;
        bus.ic_rw_wait  = ic_req;
        bus.dc_rw_wait  = dc_req;

        unique case (sel)
            OWN_I: begin
                bus.mem_addr   = bus.ic_busaddr;
                bus.mem_rd     = 1'b1;
                bus.ic_rw_wait = ~bus.mem_ready;
            end
            OWN_D: begin
                bus.mem_addr    = bus.dc_busaddr;
                bus.mem_rd      = bus.dc_rd_req;
                bus.mem_wr      = bus.dc_wr_req;
                bus.mem_wr_data = bus.dc_wr_data;
                bus.dc_rw_wait  = ~bus.mem_ready;
            end
            default: begin
                bus.mem_addr = 'x;
            end
        endcase
    end

    assign bus.ic_rd_data = bus.mem_rd_data;
    assign bus.dc_rd_data = bus.mem_rd_data;
    assign bus.grant_d    = grant_d_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each step drives one cycle of stimulus, queues the
// expected bus response, then pops and checks it mid-cycle.
module tb_bus_arbiter;

    logic clk;
    logic Nrst;

    bus_arbiter_if bus();

    bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk  (clk),
        .Nrst (Nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        icw;
        logic        dcw;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        gd;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    int          tests = 0;
    int          fails = 0;
    int          n     = 0;
    logic [31:0] wdata_drv;
    logic [31:0] rdata_drv;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic nrst, input logic ic_req, input logic [31:0] ic_addr,
                         input logic dc_rd, input logic dc_wr, input logic [31:0] dc_addr,
                         input logic lock, input logic ready);
        n++;
        wdata_drv          = 32'hA500_0000 + 32'(n);
        rdata_drv          = 32'h5A00_0000 + 32'(n);
        Nrst               = nrst;
        bus.ic_rd_req      = ic_req;
        bus.ic_busaddr     = ic_addr;
        bus.dc_rd_req      = dc_rd;
        bus.dc_wr_req      = dc_wr;
        bus.dc_busaddr     = dc_addr;
        bus.dc_wr_data     = wdata_drv;
        bus.dc_lock        = lock;
        bus.mem_ready      = ready;
        bus.mem_rd_data    = rdata_drv;
    endtask

    task automatic check_cycle;
        exp_t  e;
        string t;
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            t = tags.pop_front();
            cmp({t, ".ic_wait"}, 32'(bus.ic_rw_wait), 32'(e.icw));
            cmp({t, ".dc_wait"}, 32'(bus.dc_rw_wait), 32'(e.dcw));
            cmp({t, ".mem_rd"},  32'(bus.mem_rd),     32'(e.rd));
            cmp({t, ".mem_wr"},  32'(bus.mem_wr),     32'(e.wr));
            if (e.rd || e.wr) cmp({t, ".mem_addr"}, bus.mem_addr, e.addr);
            if (e.wr) cmp({t, ".mem_wr_data"}, bus.mem_wr_data, e.wdata);
            cmp({t, ".ic_rd_data"}, bus.ic_rd_data, e.rdata);
            cmp({t, ".dc_rd_data"}, bus.dc_rd_data, e.rdata);
            cmp({t, ".grant_d"}, 32'(bus.grant_d), 32'(e.gd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic icw, input logic dcw, input logic rd,
                        input logic wr, input logic [31:0] addr, input logic gd);
        exp_t e;
        e.icw   = icw;
        e.dcw   = dcw;
        e.rd    = rd;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata_drv;
        e.rdata = rdata_drv;
        e.gd    = gd;
        sb.push_back(e);
        tags.push_back(tag);
        check_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with both masters requesting
        drive(0, 1, 32'h40, 1, 0, 32'h100, 0, 1);
        step("rst0", 1, 1, 0, 0, 32'h0, 0);
        step("rst1", 1, 1, 0, 0, 32'h0, 0);

        // data wins four times, then fetch is forced ahead
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 32'h40, 0, 1, 32'h100, 0, 1);
            if (k == 5)
                step($sformatf("starve%0d", k), 0, 1, 1, 0, 32'h40, 1);
            else
                step($sformatf("starve%0d", k), 1, 0, 0, 1, 32'h100, (k == 1 || k == 6) ? 1'b0 : 1'b1);
        end

        // mid-transaction hold: starve reaches the limit only when the D read completes
        for (int c = 1; c <= 3; c++) begin
            drive(1, 1, 32'h40, 1, 0, 32'h200, 0, 0);
            step($sformatf("hold%0d", c), 1, 1, 1, 0, 32'h200, 1);
        end
        drive(1, 1, 32'h40, 1, 0, 32'h200, 0, 1);
        step("hold_done", 1, 0, 1, 0, 32'h200, 1);
        drive(1, 1, 32'h40, 1, 0, 32'h204, 0, 1);
        step("hold_fetch", 0, 1, 1, 0, 32'h40, 1);

        // saturate starve, then an 8-beat locked burst keeps fetch out
        for (int p = 0; p < 4; p++) begin
            drive(1, 1, 32'h40, 1, 0, 32'h300 + 32'(4 * p), 0, 1);
            step($sformatf("pre%0d", p), 1, 0, 1, 0, 32'h300 + 32'(4 * p), (p == 0) ? 1'b0 : 1'b1);
        end
        for (int b = 0; b < 8; b++) begin
            drive(1, 1, 32'h40, 1, 0, 32'h500 + 32'(4 * b), 1, 1);
            step($sformatf("lock%0d", b), 1, 0, 1, 0, 32'h500 + 32'(4 * b), 1);
        end
        drive(1, 1, 32'h40, 0, 0, 32'h0, 0, 1);
        step("unlock", 0, 0, 1, 0, 32'h40, 1);

        // fetch abandons a waiting read; pending data write granted the same cycle
        drive(1, 1, 32'h80, 0, 0, 32'h0, 0, 0);
        step("ab1", 1, 0, 1, 0, 32'h80, 0);
        drive(1, 1, 32'h80, 0, 1, 32'h600, 0, 0);
        step("ab2", 1, 1, 1, 0, 32'h80, 0);
        drive(1, 0, 32'h80, 0, 1, 32'h600, 0, 0);
        step("ab3", 0, 1, 0, 1, 32'h600, 0);
        drive(1, 0, 32'h80, 0, 1, 32'h600, 0, 1);
        step("ab4", 0, 0, 0, 1, 32'h600, 0);

        // reset pulse during a waiting D access clears starve and owner
        for (int q = 0; q < 4; q++) begin
            drive(1, 1, 32'h40, 0, 1, 32'h100, 0, 1);
            step($sformatf("prs%0d", q), 1, 0, 0, 1, 32'h100, 1);
        end
        drive(1, 1, 32'h40, 1, 0, 32'h700, 1, 0);
        step("rm_wait", 1, 1, 1, 0, 32'h700, 1);
        drive(0, 1, 32'h40, 1, 0, 32'h700, 1, 0);
        step("rm_rst", 1, 1, 0, 0, 32'h0, 1);
        drive(1, 1, 32'h40, 1, 0, 32'h700, 0, 1);
        step("rm_fresh", 1, 0, 1, 0, 32'h700, 0);
        drive(1, 1, 32'h40, 1, 0, 32'h704, 0, 1);
        step("rm_next", 1, 0, 1, 0, 32'h704, 1);

        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
